// File: rtl/dmux_seq_pkg.sv
// Shared definitions for the byte-to-demux frame sequencer.
//   state_t : sequencer FSM states (IDLE, SEND, DONE)
//   CH_NUM  : number of demux channels (one per data bit)
//   SEL_W   : width of the demux channel select
package dmux_seq_pkg;

  localparam int CH_NUM = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Even parity across data plus parity bit; a 1 means the byte is corrupt.
  function automatic logic parity_bad(input logic [CH_NUM-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/dmux_frame_seq.sv
// dmux_frame_seq: accepts one byte per frame and serialises it, bit k on
// channel k, as (sel, i) pairs driving an external 1:8 demux.
// Optional build macro: DMUX_SEQ_PARITY_EN adds in_par / parity_err.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data : byte handshake input
//   hold            : downstream stall, freezes sel and the bit counter
//   in_par          : (parity build) even-parity bit for in_data
//   parity_err      : (parity build) one-cycle pulse, byte dropped
//   sel, i          : demux select and data bit (registered)
//   out_valid       : sel/i carry a real bit this cycle
//   done            : one-cycle pulse after the last bit of a frame
module dmux_frame_seq
  import dmux_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_NUM-1:0] in_data,
  input  logic              hold,
`ifdef DMUX_SEQ_PARITY_EN
  input  logic              in_par,
  output logic              parity_err,
`endif
  output logic [SEL_W-1:0]  sel,
  output logic              i,
  output logic              out_valid,
  output logic              done
);

  state_t             state;
  logic [SEL_W-1:0]   cnt;
  logic [CH_NUM-1:0]  byte_q;
  logic               hs;
  logic               accept;

  // in_ready is forced low during reset so upstream never sees a phantom
  // acceptance while the block is held.
  assign in_ready = !rst && (state != SEND);
  assign hs       = in_valid && in_ready;

`ifdef DMUX_SEQ_PARITY_EN
  logic bad;
  assign bad    = hs && parity_bad(in_data, in_par);
  assign accept = hs && !bad;
`else
  assign accept = hs;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      byte_q     <= '0;
      sel        <= '0;
      i          <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
`ifdef DMUX_SEQ_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      // Pulse-style outputs default low; sel keeps its last value.
      i         <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
`ifdef DMUX_SEQ_PARITY_EN
      parity_err <= bad;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            byte_q <= in_data;
            cnt    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (!hold) begin
            sel       <= cnt;
            i         <= byte_q[cnt];
            out_valid <= 1'b1;
            // Counter parks at the last channel rather than wrapping;
            // the next handshake clears it.
            if (cnt == SEL_W'(CH_NUM - 1)) state <= DONE;
            else                           cnt   <= cnt + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
          if (accept) begin
            byte_q <= in_data;
            cnt    <= '0;
            state  <= SEND;
          end else begin
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmux_frame_seq.sv
// Self-checking bench for dmux_frame_seq: table of frames with optional
// stalls, plus directed back-to-back, reset-abort and parity sequences.
// A scoreboard queue holds expected (sel, i) pairs pushed at handshake.
module tb_dmux_frame_seq;
  import dmux_seq_pkg::*;

  logic       clk = 0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       hold;
  logic [2:0] sel;
  logic       i;
  logic       out_valid;
  logic       done;
`ifdef DMUX_SEQ_PARITY_EN
  logic       in_par;
  logic       parity_err;
`endif

  dmux_frame_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .hold(hold),
`ifdef DMUX_SEQ_PARITY_EN
    .in_par(in_par), .parity_err(parity_err),
`endif
    .sel(sel), .i(i), .out_valid(out_valid), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] sel; logic i; } exp_t;
  exp_t q[$];

  typedef struct {
    logic [7:0] data;
    int         hold_sel;
    int         hold_len;
    int         exp_lat;   // edges from handshake to done visible
  } frame_t;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      e.sel = 3'(k);
      e.i   = d[k];
      q.push_back(e);
    end
  endtask

  // Scoreboard consumer and done counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", {29'd0, sel}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_sel", {29'd0, sel}, {29'd0, e.sel});
          chk("sb_i", {31'd0, i}, {31'd0, e.i});
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_without_ov", {31'd0, out_valid}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame with an optional stall of hold_len cycles right after the
  // channel hold_sel has been presented.
  task automatic run_frame(input frame_t f);
    int  hrem;
    bit  hon;
    int  lat;
    int  dc0;
    int  w;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    chk("ready_before_frame", {31'd0, in_ready}, 32'd1);
    dc0      = done_cnt;
    in_valid = 1;
    in_data  = f.data;
`ifdef DMUX_SEQ_PARITY_EN
    in_par   = ^f.data;
`endif
    tick();
    push_byte(f.data);
    in_valid = 0;
    in_data  = ~f.data;   // frame in flight must ignore this
    hrem = f.hold_len;
    hon  = 0;
    lat  = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (hon) begin
        chk("hold_ov", {31'd0, out_valid}, 32'd0);
        chk("hold_i", {31'd0, i}, 32'd0);
        chk("hold_sel", {29'd0, sel}, f.hold_sel);
        hrem--;
      end
      if (out_valid) chk("ready_in_send", {31'd0, in_ready}, {31'd0, (sel == 3'd7)});
      if (done) begin lat = c; break; end
      hon  = (hrem > 0) && (hon || (out_valid && sel == 3'(f.hold_sel)));
      hold = hon;
    end
    hold = 0;
    chk("frame_latency", lat, f.exp_lat);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("done_count", done_cnt - dc0, 1);
    chk("sb_empty", q.size(), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  frame_t tbl[5];

  initial begin
    int dc;
    tbl[0] = '{8'hA5, 0, 0, 9};
    tbl[1] = '{8'h80, 3, 3, 12};
    tbl[2] = '{8'h3C, 0, 1, 10};
    tbl[3] = '{8'hC3, 7, 2, 9};   // stall while in DONE has no effect
    tbl[4] = '{8'h5A, 5, 4, 13};

    rst = 1; in_valid = 0; in_data = 0; hold = 0;
`ifdef DMUX_SEQ_PARITY_EN
    in_par = 0;
`endif
    #12;
    chk("rst_sel", {29'd0, sel}, 0);
    chk("rst_i", {31'd0, i}, 0);
    chk("rst_ov", {31'd0, out_valid}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ready", {31'd0, in_ready}, 0);
    @(negedge clk); rst = 0;
    tick();
    chk("ready_after_rst", {31'd0, in_ready}, 1);

    for (int n = 0; n < 5; n++) run_frame(tbl[n]);

    // Back-to-back: FF then 00 with in_valid held high.
    chk("b2b_ready_idle", {31'd0, in_ready}, 1);
    dc = done_cnt;
    in_valid = 1; in_data = 8'hFF;
`ifdef DMUX_SEQ_PARITY_EN
    in_par = 0;
`endif
    tick();
    push_byte(8'hFF);
    in_data = 8'h00;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 9) begin push_byte(8'h00); in_valid = 0; end
      chk("b2b_ready", {31'd0, in_ready}, {31'd0, (c % 9 == 8) || c == 18});
      chk("b2b_ov", {31'd0, out_valid}, {31'd0, (c % 9 != 0)});
      chk("b2b_done", {31'd0, done}, {31'd0, (c == 9 || c == 18)});
      if (out_valid) chk("b2b_sel_seq", {29'd0, sel}, (c - 1) % 9);
    end
    tick();
    chk("b2b_done_count", done_cnt - dc, 2);

    // Reset in the middle of a frame at sel=4.
    in_valid = 1; in_data = 8'hF0;
`ifdef DMUX_SEQ_PARITY_EN
    in_par = 0;
`endif
    tick();
    push_byte(8'hF0);
    in_valid = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid && sel == 3'd4) break;
    end
    chk("abort_at_sel4", {30'd0, out_valid, (sel == 3'd4)}, 32'd3);
    #2 rst = 1;
    #1;
    chk("abort_sel", {29'd0, sel}, 0);
    chk("abort_ov", {31'd0, out_valid}, 0);
    chk("abort_i", {31'd0, i}, 0);
    chk("abort_ready", {31'd0, in_ready}, 0);
    q.delete();
    dc = done_cnt;
    @(negedge clk); rst = 0;
    #1;
    chk("abort_ready_release", {31'd0, in_ready}, 1);
    repeat (12) tick();
    chk("abort_no_done", done_cnt - dc, 0);
    run_frame('{8'h96, 0, 0, 9});

`ifdef DMUX_SEQ_PARITY_EN
    // Bad parity byte is dropped.
    dc = done_cnt;
    in_valid = 1; in_data = 8'h01; in_par = 0;
    tick();
    in_valid = 0;
    chk("par_err_pulse", {31'd0, parity_err}, 1);
    chk("par_ready", {31'd0, in_ready}, 1);
    tick();
    chk("par_err_clear", {31'd0, parity_err}, 0);
    repeat (10) tick();
    chk("par_no_done", done_cnt - dc, 0);
    run_frame('{8'h01, 0, 0, 9});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmux_frame_seq.md
DMUX_FRAME_SEQ -- requirements
Module: dmux_frame_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Ports (name / direction / width / meaning):
- clk / input / 1 / single rising-edge clock.
- rst / input / 1 / asynchronous active-high reset.
- in_valid / input / 1 / byte offered.
- in_ready / output / 1 / block can accept a byte.
- in_data / input / 8 / byte to distribute, bit k destined for channel k.
- hold / input / 1 / stall request from downstream.
- sel / output / 3 / channel select feeding the 1:8 demux select.
- i / output / 1 / data bit feeding the 1:8 demux input.
- out_valid / output / 1 / sel and i carry a valid bit this cycle.
- done / output / 1 / one-cycle pulse, frame completed.
REQ-003 All outputs except in_ready SHALL be registered; in_ready SHALL be decoded from the current state only.

Function
REQ-004 FSM states SHALL be IDLE, SEND and DONE.
REQ-005 A handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-006 in_ready SHALL be 1 in IDLE and DONE, and 0 in SEND.
REQ-007 On a handshake, in_data SHALL be captured, the bit counter SHALL be cleared to 0, and the state SHALL become SEND.
REQ-008 In SEND with hold=0, each cycle SHALL present sel=counter, i=byte[counter], out_valid=1, then increment the counter.
REQ-009 In SEND with hold=1, sel and the counter SHALL be frozen, and i and out_valid SHALL be 0, so all demux outputs are 0.
REQ-010 After the unstalled cycle with sel=7, the state SHALL become DONE.
REQ-011 In DONE, done=1 for exactly one cycle and out_valid=0.
REQ-012 From DONE, the state SHALL go to SEND on a handshake, otherwise to IDLE.
REQ-013 Latency: for a handshake at edge N with no hold, sel=0 is valid after edge N+1, sel=7 after edge N+8, and done after edge N+9.
REQ-014 Throughput SHALL be one byte per 9 cycles when in_valid is held high.
REQ-015 In IDLE, sel SHALL keep its last value, i=0 and out_valid=0.
REQ-016 The 3-bit counter SHALL not wrap inside a frame; the transition out of sel=7 always goes to DONE.
REQ-017 hold SHALL have no effect in IDLE or DONE.
REQ-018 in_data changes after a handshake SHALL not affect the frame in flight.

Reset
REQ-019 On rst=1, the block SHALL asynchronously enter IDLE with sel=0, i=0, out_valid=0, done=0, counter=0 and the captured byte=0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no done pulse.
REQ-021 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.

Configuration
REQ-022 The macro DMUX_SEQ_PARITY_EN SHALL compile parity checking in or out.
REQ-023 With DMUX_SEQ_PARITY_EN defined:
- input in_par (1 bit) and output parity_err (1 bit, registered, reset 0) SHALL be added.
- On a handshake where the XOR of in_data and in_par is 1, the byte SHALL be dropped, parity_err SHALL pulse for one cycle, and the state SHALL go to (or stay in) IDLE with no done.
- Good parity SHALL behave as REQ-007.
REQ-024 Without DMUX_SEQ_PARITY_EN, in_par and parity_err SHALL be absent and every accepted byte SHALL be sent.

Structure
REQ-025 A package dmux_seq_pkg SHALL hold the state enum (IDLE, SEND, DONE) and the constants CH_NUM=8 and SEL_W=3.
REQ-026 The block SHALL be a single module with no sub-module; the 1:8 demux SHALL be instantiated by the parent, not inside this block.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, then one handshake with in_data=8'hA5 and hold=0: out_valid for 8 cycles, sel 0..7, i=1,0,1,0,0,1,0,1, then done for one cycle.
- in_valid held high with bytes 8'hFF then 8'h00: the second frame's sel=0 cycle immediately follows the first frame's DONE cycle; i all 1 then all 0; in_ready=0 throughout both SEND periods.
- in_data=8'h80 with hold=1 for 3 cycles at sel=3: sel stays at 3 for 3 cycles with i=0 and out_valid=0; the sel=7 cycle drives i=1; done arrives 3 cycles late (after edge 12).
- rst asserted at sel=4: all outputs go 0 immediately; no done; in_ready=1 after release; the next byte starts at sel=0.
- DMUX_SEQ_PARITY_EN with in_data=8'h01 and in_par=0: parity_err pulses, no out_valid, no done. Then in_par=1: the frame is sent normally.
